// File: rtl/seq_multiplier_ctrl_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier controller:
// FSM state encoding and small helpers used by the control logic.
package seq_multiplier_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NEG_A  = 3'd1,
    NEG_B  = 3'd2,
    MUL    = 3'd3,
    FIX_LO = 3'd4,
    FIX_HI = 3'd5,
    DONE   = 3'd6
  } state_e;

  // An operand needs negating only when signed and its MSB is set.
  function automatic logic needs_neg(input logic sm, input logic msb);
    return sm & msb;
  endfunction

endpackage

// File: rtl/seq_multiplier_ctrl_cla.sv
// WIDTH-bit carry-lookahead adder with optional inversion of the b operand,
// time-shared by every arithmetic step of the multiplier.
module seq_multiplier_ctrl_cla #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             inv_b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  always_comb begin
    bx   = inv_b ? ~b : b;
    g    = a & bx;
    p    = a ^ bx;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum  = p ^ c[WIDTH-1:0];
    cout = c[WIDTH];
  end

endmodule

// File: rtl/seq_multiplier_ctrl.sv
// Multi-cycle shift-and-add multiplier: sign-magnitude conversion, WIDTH add/shift
// iterations and a final two-word negate, all through one shared adder.
module seq_multiplier_ctrl
  import seq_multiplier_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     mq_q, mq_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sm_q, sm_d;
  logic                 sign_q, sign_d;
  logic                 brw_q, brw_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     add_a, add_b, add_sum;
  logic                 add_cin, add_inv, add_cout;

  seq_multiplier_ctrl_cla #(.WIDTH(WIDTH)) u_cla (
    .a     (add_a),
    .b     (add_b),
    .cin   (add_cin),
    .inv_b (add_inv),
    .sum   (add_sum),
    .cout  (add_cout)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    mq_d      = mq_q;
    hi_d      = hi_q;
    cnt_d     = cnt_q;
    sm_d      = sm_q;
    sign_d    = sign_q;
    brw_d     = brw_q;
    product_d = product_q;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    add_inv   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = x;
          mq_d    = y;
          sm_d    = signed_mode;
          sign_d  = signed_mode & (x[WIDTH-1] ^ y[WIDTH-1]);
          state_d = NEG_A;
        end
      end
      NEG_A: begin
        add_b   = a_q;
        add_inv = 1'b1;
        add_cin = 1'b1;
        if (needs_neg(sm_q, a_q[WIDTH-1])) a_d = add_sum;
        state_d = NEG_B;
      end
      NEG_B: begin
        add_b   = mq_q;
        add_inv = 1'b1;
        add_cin = 1'b1;
        if (needs_neg(sm_q, mq_q[WIDTH-1])) mq_d = add_sum;
        hi_d    = '0;
        cnt_d   = '0;
        state_d = MUL;
      end
      MUL: begin
        // Carry-out becomes the new MSB of the high word as the pair shifts right.
        add_a = hi_q;
        add_b = mq_q[0] ? a_q : '0;
        hi_d  = {add_cout, add_sum[WIDTH-1:1]};
        mq_d  = {add_sum[0], mq_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = FIX_LO;
      end
      FIX_LO: begin
        add_b   = mq_q;
        add_inv = 1'b1;
        add_cin = 1'b1;
        if (sign_q) begin
          mq_d  = add_sum;
          brw_d = add_cout;
        end
        state_d = FIX_HI;
      end
      FIX_HI: begin
        // Product is loaded here so it is already valid in the DONE cycle.
        add_a   = ~hi_q;
        add_cin = brw_q;
        if (sign_q) hi_d = add_sum;
        product_d = {hi_d, mq_q};
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      mq_q      <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
      sm_q      <= 1'b0;
      sign_q    <= 1'b0;
      brw_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      mq_q      <= mq_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      sm_q      <= sm_d;
      sign_q    <= sign_d;
      brw_q     <= brw_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule
